// File: rtl/cci_rd_req_scheduler.sv
// cci_rd_req_scheduler: credit-throttled c0 line-read sequencer for a CCI-P copy/filter AFU.
// Optional statistics counters are built only when CCI_RD_SCHED_STATS_EN is defined.
module cci_rd_req_scheduler #(
    parameter int ADDR_WIDTH      = 42,
    parameter int CNT_WIDTH       = 32,
    parameter int MDATA_WIDTH     = 16,
    parameter int MAX_OUTSTANDING = 62
) (
    input  logic                   Clk,
    input  logic                   Resetb,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [CNT_WIDTH-1:0]   num_lines,
    input  logic                   c0TxAlmFull,
    input  logic                   c1TxAlmFull,
    input  logic                   wr_fifo_almFull,
    input  logic                   wr_rsp_valid,
    input  logic [1:0]             wr_rsp_cl_num,
    output logic                   rd_req_valid,
    output logic [ADDR_WIDTH-1:0]  rd_req_addr,
    output logic [MDATA_WIDTH-1:0] rd_req_mdata,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   lines_issued,
    output logic [7:0]             outstanding,
    output logic                   err,
    output logic [31:0]            stall_cycles,
    output logic [63:0]            run_cycles
);
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]  idx, n_lines;
    logic [ADDR_WIDTH-1:0] base;
    logic                  accept, pending, issue, retire_en, under;
    logic [2:0]            retire_lines;
    logic [8:0]            out_sum;
    logic [7:0]            out_nxt;

    assign accept    = state == IDLE && start;
    assign pending   = idx < n_lines;
    assign issue     = state == RUN && !abort && pending && !c0TxAlmFull && !c1TxAlmFull
                       && !wr_fifo_almFull && outstanding < MAX_OUT;
    assign retire_en = wr_rsp_valid && (state == RUN || state == DRAIN);
    // cl_num 2 is illegal; it still retires one line so the credit count stays conservative
    assign retire_lines = !retire_en ? 3'd0 : wr_rsp_cl_num == 2'd3 ? 3'd4 :
                          wr_rsp_cl_num == 2'd1 ? 3'd2 : 3'd1;
    assign out_sum   = {1'b0, outstanding} + {8'd0, issue};
    assign under     = out_sum < {6'd0, retire_lines};
    assign out_nxt   = under ? 8'd0 : 8'(out_sum - {6'd0, retire_lines});

    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign lines_issued = idx;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? (num_lines == '0 ? DONE : RUN) : IDLE;
            RUN:     state_nxt = (abort || !pending) ? ((!abort && outstanding == 8'd0) ? DONE : DRAIN) : RUN;
            DRAIN:   state_nxt = outstanding == 8'd0 ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            state        <= IDLE;
            idx          <= '0;
            n_lines      <= '0;
            base         <= '0;
            outstanding  <= 8'd0;
            err          <= 1'b0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_mdata <= '0;
        end else begin
            state        <= state_nxt;
            rd_req_valid <= issue;
            if (accept) begin
                base        <= src_addr;
                n_lines     <= num_lines;
                idx         <= '0;
                outstanding <= 8'd0;
                err         <= 1'b0;
            end else begin
                if (issue) begin
                    rd_req_addr  <= base + ADDR_WIDTH'(idx);
                    rd_req_mdata <= idx[MDATA_WIDTH-1:0];
                    idx          <= idx + 1'b1;
                end
                outstanding <= out_nxt;
                if (retire_en && (under || wr_rsp_cl_num == 2'd2))
                    err <= 1'b1;
            end
        end
    end

`ifdef CCI_RD_SCHED_STATS_EN
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            stall_cycles <= '0;
            run_cycles   <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
            run_cycles   <= '0;
        end else begin
            if (state == RUN && pending && !issue && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (state == RUN || state == DRAIN)
                run_cycles <= run_cycles + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign run_cycles   = '0;
`endif

endmodule

// File: tb/tb_cci_rd_req_scheduler.sv
// tb_cci_rd_req_scheduler: directed checks of two scheduler instances (credit limit 62 and 4).
module tb_cci_rd_req_scheduler;
    logic        clk, Resetb, start_a, start_b, abort;
    logic [41:0] src_addr;
    logic [31:0] num_lines;
    logic        c0af, c1af, wfaf, wr_rsp_valid;
    logic [1:0]  wr_rsp_cl_num;

    logic        va, busy_a, done_a, err_a;
    logic [41:0] addr_a;
    logic [15:0] md_a;
    logic [31:0] li_a, st_a;
    logic [7:0]  out_a;
    logic [63:0] rc_a;

    logic        vb, busy_b, done_b, err_b;
    logic [41:0] addr_b;
    logic [15:0] md_b;
    logic [31:0] li_b, st_b;
    logic [7:0]  out_b;
    logic [63:0] rc_b;

    int          n_chk, n_fail, cyc, va_cnt, vb_cnt, da, db, first_a, last_a;
    logic [41:0] a_base, b_base;
    logic        auto_ret;
    logic [2:0]  pipe;

`ifdef CCI_RD_SCHED_STATS_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    cci_rd_req_scheduler dut_a (
        .Clk(clk), .Resetb(Resetb), .start(start_a), .abort(abort), .src_addr(src_addr),
        .num_lines(num_lines), .c0TxAlmFull(c0af), .c1TxAlmFull(c1af), .wr_fifo_almFull(wfaf),
        .wr_rsp_valid(wr_rsp_valid), .wr_rsp_cl_num(wr_rsp_cl_num), .rd_req_valid(va),
        .rd_req_addr(addr_a), .rd_req_mdata(md_a), .busy(busy_a), .done(done_a),
        .lines_issued(li_a), .outstanding(out_a), .err(err_a), .stall_cycles(st_a),
        .run_cycles(rc_a)
    );

    cci_rd_req_scheduler #(.MAX_OUTSTANDING(4)) dut_b (
        .Clk(clk), .Resetb(Resetb), .start(start_b), .abort(abort), .src_addr(src_addr),
        .num_lines(num_lines), .c0TxAlmFull(c0af), .c1TxAlmFull(c1af), .wr_fifo_almFull(wfaf),
        .wr_rsp_valid(wr_rsp_valid), .wr_rsp_cl_num(wr_rsp_cl_num), .rd_req_valid(vb),
        .rd_req_addr(addr_b), .rd_req_mdata(md_b), .busy(busy_b), .done(done_b),
        .lines_issued(li_b), .outstanding(out_b), .err(err_b), .stall_cycles(st_b),
        .run_cycles(rc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance n clocks, sampling #1 after each edge; every request address/tag is checked
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (va) begin
                chk("a_addr", 64'(addr_a), 64'(a_base + 42'(va_cnt)));
                chk("a_mdata", 64'(md_a), 64'(va_cnt[15:0]));
                if (va_cnt == 0) first_a = cyc;
                last_a = cyc;
                va_cnt++;
            end
            if (vb) begin
                chk("b_addr", 64'(addr_b), 64'(b_base + 42'(vb_cnt)));
                chk("b_mdata", 64'(md_b), 64'(vb_cnt[15:0]));
                vb_cnt++;
            end
            if (done_a) da++;
            if (done_b) db++;
            if (auto_ret) begin
                pipe = {pipe[1:0], va};
                wr_rsp_valid = pipe[2];
            end
        end
    endtask

    task automatic retire(input logic [1:0] cl);
        wr_rsp_valid  = 1'b1;
        wr_rsp_cl_num = cl;
        run(1);
        wr_rsp_valid  = 1'b0;
        wr_rsp_cl_num = 2'd0;
    endtask

    task automatic go_a(input logic [41:0] src, input logic [31:0] n);
        src_addr = src; num_lines = n; a_base = src;
        va_cnt = 0; da = 0;
        start_a = 1'b1;
        run(1);
        start_a = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; va_cnt = 0; vb_cnt = 0; da = 0; db = 0;
        first_a = 0; last_a = 0; a_base = '0; b_base = '0; auto_ret = 1'b0; pipe = '0;
        start_a = 0; start_b = 0; abort = 0; src_addr = '0; num_lines = '0;
        c0af = 0; c1af = 0; wfaf = 0; wr_rsp_valid = 0; wr_rsp_cl_num = 2'd0;
        Resetb = 1'b1;
        #2 Resetb = 1'b0;
        #20;
        chk("rst_valid", 64'(va), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_outstanding", 64'(out_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk("rst_lines_issued", 64'(li_a), 64'd0);
        chk("rst_stall", 64'(st_a), 64'd0);
        chk("rst_run_cycles", rc_a, 64'd0);
        @(posedge clk); #1 Resetb = 1'b1;
        run(2);

        // 1: four back-to-back reads, each retired three cycles later
        auto_ret = 1'b1;
        go_a(42'h1000, 32'd4);
        run(15);
        auto_ret = 1'b0; wr_rsp_valid = 1'b0;
        chk("t1_count", 64'(va_cnt), 64'd4);
        chk("t1_consecutive", 64'(last_a - first_a), 64'd3);
        chk("t1_done_once", 64'(da), 64'd1);
        chk("t1_outstanding", 64'(out_a), 64'd0);
        chk("t1_lines_issued", 64'(li_a), 64'd4);
        chk("t1_busy_end", 64'(busy_a), 64'd0);
        chk("t1_err", 64'(err_a), 64'd0);

        // 2: credit limit of 4 on instance b
        src_addr = 42'h2000; num_lines = 32'd10; b_base = 42'h2000;
        vb_cnt = 0; db = 0;
        start_b = 1'b1; run(1); start_b = 1'b0;
        run(12);
        chk("t2_first_burst", 64'(vb_cnt), 64'd4);
        chk("t2_outstanding_full", 64'(out_b), 64'd4);
        retire(2'd1);
        run(8);
        chk("t2_after_two", 64'(vb_cnt), 64'd6);
        chk("t2_done_early", 64'(db), 64'd0);
        retire(2'd3);
        run(8);
        chk("t2_all_issued", 64'(vb_cnt), 64'd10);
        retire(2'd3);
        run(5);
        chk("t2_done_once", 64'(db), 64'd1);
        chk("t2_outstanding_end", 64'(out_b), 64'd0);
        chk("t2_lines_issued", 64'(li_b), 64'd10);
        chk("t2_busy_end", 64'(busy_b), 64'd0);

        // 3: five-cycle c0 almost-full stall mid-run
        go_a(42'h3000, 32'd8);
        run(2);
        chk("t3_pre_stall", 64'(va_cnt), 64'd2);
        c0af = 1'b1;
        run(5);
        c0af = 1'b0;
        chk("t3_no_valid_in_stall", 64'(va_cnt), 64'd2);
        run(1);
        chk("t3_resume", 64'(va_cnt), 64'd3);
        run(10);
        chk("t3_all_issued", 64'(va_cnt), 64'd8);
        chk("t3_stall_cycles", 64'(st_a), 64'(EXP_STALL));
        retire(2'd3);
        retire(2'd3);
        run(4);
        chk("t3_done_once", 64'(da), 64'd1);
        chk("t3_outstanding_end", 64'(out_a), 64'd0);

        // 4: zero-length run, then a retire while idle
        go_a(42'h5000, 32'd0);
        chk("t4_busy", 64'(busy_a), 64'd1);
        chk("t4_done", 64'(done_a), 64'd1);
        run(1);
        chk("t4_busy_off", 64'(busy_a), 64'd0);
        chk("t4_done_off", 64'(done_a), 64'd0);
        retire(2'd3);
        chk("t4_no_requests", 64'(va_cnt), 64'd0);
        chk("t4_idle_retire_out", 64'(out_a), 64'd0);
        chk("t4_idle_retire_err", 64'(err_a), 64'd0);

        // 5: abort after 10 issued and 6 retired, then drain the remaining 4
        go_a(42'h4000, 32'd100);
        run(8);
        retire(2'd1);
        retire(2'd3);
        abort = 1'b1;
        run(1);
        abort = 1'b0;
        chk("t5_issued_at_abort", 64'(va_cnt), 64'd10);
        chk("t5_outstanding", 64'(out_a), 64'd4);
        chk("t5_lines_issued", 64'(li_a), 64'd10);
        run(5);
        chk("t5_no_issue_in_drain", 64'(va_cnt), 64'd10);
        chk("t5_busy_drain", 64'(busy_a), 64'd1);
        chk("t5_no_early_done", 64'(da), 64'd0);
        retire(2'd3);
        run(3);
        chk("t5_done_once", 64'(da), 64'd1);
        chk("t5_lines_issued_end", 64'(li_a), 64'd10);

        // 6: retire underflow, sticky err, cleared by start, cl_num=2, async reset
        c0af = 1'b1;
        go_a(42'h0, 32'd4);
        retire(2'd0);
        chk("t6_underflow_err", 64'(err_a), 64'd1);
        chk("t6_underflow_sat", 64'(out_a), 64'd0);
        abort = 1'b1;
        run(1);
        abort = 1'b0;
        run(3);
        chk("t6_abort_done", 64'(da), 64'd1);
        chk("t6_err_held", 64'(err_a), 64'd1);
        c0af = 1'b0;
        go_a(42'h0, 32'd4);
        chk("t6_err_cleared", 64'(err_a), 64'd0);
        run(2);
        retire(2'd2);
        chk("t6_cl2_err", 64'(err_a), 64'd1);
        chk("t6_cl2_retires_one", 64'(out_a), 64'd2);
        da = 0;
        Resetb = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(va), 64'd0);
        chk("t6_rst_busy", 64'(busy_a), 64'd0);
        chk("t6_rst_err", 64'(err_a), 64'd0);
        chk("t6_rst_outstanding", 64'(out_a), 64'd0);
        chk("t6_rst_lines", 64'(li_a), 64'd0);
        chk("t6_rst_addr", 64'(addr_a), 64'd0);
        run(3);
        chk("t6_no_done_after_reset", 64'(da), 64'd0);
        Resetb = 1'b1;
        run(2);
        chk("t6_idle_after_reset", 64'(busy_a), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
